// File: rtl/thinpad_sram_chk_pkg.sv
// Shared types and constants for the thinpad SRAM AXI self-test master.
// Holds the FSM state encoding, AXI response codes and LFSR pattern constants.
package thinpad_sram_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } chk_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/thinpad_sram_chk_pattern.sv
// Test-pattern generator: one value per beat, restartable with clear.
// THINPAD_SRAM_CHK_LFSR_EN selects a replicated 32-bit Galois LFSR instead of an n+1 counter.
module thinpad_sram_chk_pattern
  import thinpad_sram_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data
);

`ifdef THINPAD_SRAM_CHK_LFSR_EN
  localparam int REPS = (DATA_WIDTH + 31) / 32;

  logic [31:0]        lfsr_reg;
  logic [31:0]        lfsr_next;
  logic [REPS*32-1:0] lfsr_rep;

  always_comb begin
    lfsr_next = lfsr_reg >> 1;
    if (lfsr_reg[0]) begin
      lfsr_next = (lfsr_reg >> 1) ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      lfsr_reg <= LFSR_SEED;
    end else if (advance) begin
      lfsr_reg <= lfsr_next;
    end
  end

  // The 32-bit state is copied into every lane of a wider data bus.
  generate
    for (genvar gi = 0; gi < REPS; gi++) begin : g_rep
      assign lfsr_rep[gi*32 +: 32] = lfsr_reg;
    end
  endgenerate

  assign data = lfsr_rep[DATA_WIDTH-1:0];
`else
  logic [DATA_WIDTH-1:0] count_reg;

  // Beat n carries n+1, so the counter restarts at 1.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= DATA_WIDTH'(1);
    end else if (advance) begin
      count_reg <= count_reg + DATA_WIDTH'(1);
    end
  end

  assign data = count_reg;
`endif

endmodule

// File: rtl/thinpad_sram_axi_checker.sv
// AXI4 master that writes NUM_BURSTS bursts of a known pattern, reads them back and counts errors.
// Build option THINPAD_SRAM_CHK_LFSR_EN switches the pattern to an LFSR.
module thinpad_sram_axi_checker
  import thinpad_sram_chk_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            BURST_LEN          = 8,
  parameter int                            NUM_BURSTS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          START,
  output logic                          DONE,
  output logic                          PASS,
  output logic [15:0]                   ERR_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    C_M_AXI_ADDR_WIDTH'(BURST_LEN * beat_bytes(C_M_AXI_DATA_WIDTH));

  chk_state_t                    state_reg, state_next;
  logic [7:0]                    beat_reg, beat_next;
  logic [15:0]                   burst_reg, burst_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]                   err_reg, err_next;
  logic [16:0]                   err_sum;
  logic [2:0]                    err_inc;
  logic                          err_clear;
  logic                          pat_clear;

  logic                          wr_fire;
  logic                          rd_fire;
  logic                          last_beat;
  logic                          last_burst;
  logic                          rd_data_bad;
  logic                          rd_resp_bad;
  logic                          rd_last_bad;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_pattern;
  logic [C_M_AXI_DATA_WIDTH-1:0] rd_pattern;

  thinpad_sram_chk_pattern #(
    .DATA_WIDTH(C_M_AXI_DATA_WIDTH)
  ) u_wr_pattern (
    .clk    (ACLK),
    .srst   (ARESET),
    .clear  (pat_clear),
    .advance(wr_fire),
    .data   (wr_pattern)
  );

  // Read expectation restarts from the same seed as the writer at every START.
  thinpad_sram_chk_pattern #(
    .DATA_WIDTH(C_M_AXI_DATA_WIDTH)
  ) u_rd_pattern (
    .clk    (ACLK),
    .srst   (ARESET),
    .clear  (pat_clear),
    .advance(rd_fire),
    .data   (rd_pattern)
  );

  assign wr_fire     = M_AXI_WVALID && M_AXI_WREADY;
  assign rd_fire     = M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat   = (beat_reg == LAST_BEAT);
  assign last_burst  = (burst_reg == LAST_BURST);
  assign rd_data_bad = (M_AXI_RDATA != rd_pattern);
  assign rd_resp_bad = (M_AXI_RRESP != AXI_RESP_OKAY);
  assign rd_last_bad = (M_AXI_RLAST != last_beat);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
      burst_reg <= '0;
      addr_reg  <= BASE_ADDR;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      burst_reg <= burst_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    burst_next = burst_reg;
    addr_next  = addr_reg;
    err_clear  = 1'b0;
    err_inc    = 3'd0;
    pat_clear  = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_next = S_AW;
          beat_next  = '0;
          burst_next = '0;
          addr_next  = BASE_ADDR;
          err_clear  = 1'b1;
          pat_clear  = 1'b1;
        end
      end
      S_AW: begin
        if (M_AXI_AWREADY) state_next = S_W;
      end
      S_W: begin
        if (M_AXI_WREADY) begin
          if (last_beat) begin
            beat_next  = '0;
            state_next = S_B;
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      S_B: begin
        if (M_AXI_BVALID) begin
          err_inc = 3'(M_AXI_BRESP != AXI_RESP_OKAY);
          if (last_burst) begin
            burst_next = '0;
            addr_next  = BASE_ADDR;
            state_next = S_AR;
          end else begin
            burst_next = burst_reg + 16'd1;
            addr_next  = addr_reg + BURST_BYTES;
            state_next = S_AW;
          end
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) state_next = S_R;
      end
      S_R: begin
        if (M_AXI_RVALID) begin
          // Each fault class contributes independently, so one beat can add up to three.
          err_inc = 3'(rd_data_bad) + 3'(rd_resp_bad) + 3'(rd_last_bad);
          if (last_beat) begin
            beat_next = '0;
            if (last_burst) begin
              state_next = S_DONE;
            end else begin
              burst_next = burst_reg + 16'd1;
              addr_next  = addr_reg + BURST_BYTES;
              state_next = S_AR;
            end
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    err_sum = {1'b0, err_reg} + 17'(err_inc);
    if (err_clear) begin
      err_next = '0;
    end else if (err_sum[16]) begin
      err_next = 16'hFFFF;
    end else begin
      err_next = err_sum[15:0];
    end
  end

  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWVALID = (state_reg == S_AW);
  assign M_AXI_WDATA   = wr_pattern;
  assign M_AXI_WLAST   = (state_reg == S_W) && last_beat;
  assign M_AXI_WVALID  = (state_reg == S_W);
  assign M_AXI_BREADY  = (state_reg == S_B);
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARVALID = (state_reg == S_AR);
  assign M_AXI_RREADY  = (state_reg == S_R);

  assign DONE    = (state_reg == S_DONE);
  assign PASS    = DONE && (err_reg == 16'd0);
  assign ERR_CNT = err_reg;

endmodule

// File: tb/tb_thinpad_sram_axi_checker.sv
// Bench for thinpad_sram_axi_checker: a 32-bit default instance against a memory slave model
// with fault injection and stalls, plus a 64-bit single-beat instance against an ideal slave.
module tb_thinpad_sram_axi_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: defaults (32-bit, 8 beats, 4 bursts)
  logic        start_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [31:0] awaddr_a, araddr_a, wdata_a, rdata_a;
  logic [7:0]  awlen_a, arlen_a;
  logic        awvalid_a, awready_a, wlast_a, wvalid_a, wready_a;
  logic [1:0]  bresp_a, rresp_a;
  logic        bvalid_a, bready_a, arvalid_a, arready_a, rlast_a, rvalid_a, rready_a;

  // Instance B: 64-bit data, one beat, one burst
  logic        start_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [31:0] awaddr_b, araddr_b;
  logic [63:0] wdata_b, rdata_b;
  logic [7:0]  awlen_b, arlen_b;
  logic        awvalid_b, wlast_b, wvalid_b, bvalid_b, bready_b, arvalid_b, rvalid_b, rready_b;

  thinpad_sram_axi_checker dut_a (
    .ACLK(clk), .ARESET(rst), .START(start_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a),
    .M_AXI_AWADDR(awaddr_a), .M_AXI_AWLEN(awlen_a), .M_AXI_AWVALID(awvalid_a), .M_AXI_AWREADY(awready_a),
    .M_AXI_WDATA(wdata_a), .M_AXI_WLAST(wlast_a), .M_AXI_WVALID(wvalid_a), .M_AXI_WREADY(wready_a),
    .M_AXI_BRESP(bresp_a), .M_AXI_BVALID(bvalid_a), .M_AXI_BREADY(bready_a),
    .M_AXI_ARADDR(araddr_a), .M_AXI_ARLEN(arlen_a), .M_AXI_ARVALID(arvalid_a), .M_AXI_ARREADY(arready_a),
    .M_AXI_RDATA(rdata_a), .M_AXI_RRESP(rresp_a), .M_AXI_RLAST(rlast_a), .M_AXI_RVALID(rvalid_a),
    .M_AXI_RREADY(rready_a)
  );

  thinpad_sram_axi_checker #(
    .C_M_AXI_DATA_WIDTH(64), .BURST_LEN(1), .NUM_BURSTS(1)
  ) dut_b (
    .ACLK(clk), .ARESET(rst), .START(start_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b),
    .M_AXI_AWADDR(awaddr_b), .M_AXI_AWLEN(awlen_b), .M_AXI_AWVALID(awvalid_b), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(wdata_b), .M_AXI_WLAST(wlast_b), .M_AXI_WVALID(wvalid_b), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid_b), .M_AXI_BREADY(bready_b),
    .M_AXI_ARADDR(araddr_b), .M_AXI_ARLEN(arlen_b), .M_AXI_ARVALID(arvalid_b), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(rdata_b), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b1), .M_AXI_RVALID(rvalid_b),
    .M_AXI_RREADY(rready_b)
  );

  // Expected pattern for global beat n.
  function automatic logic [31:0] pat32(input int n);
    logic [31:0] s;
`ifdef THINPAD_SRAM_CHK_LFSR_EN
    s = 32'h1;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
`else
    s = 32'(n + 1);
`endif
    return s;
  endfunction

  function automatic logic [63:0] pat64(input int n);
`ifdef THINPAD_SRAM_CHK_LFSR_EN
    return {pat32(n), pat32(n)};
`else
    return 64'(n + 1);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [31:0] q_aw[$];
  logic [31:0] q_ar[$];
  logic [32:0] q_w[$];     // {wlast, wdata}
  logic [16:0] q_done[$];  // {pass, err_cnt}
  logic [64:0] q_w64[$];
  logic [16:0] q_done64[$];

  task automatic push_run_a(input int exp_err);
    for (int b = 0; b < 4; b++) begin
      q_aw.push_back(32'(b * 32));
      q_ar.push_back(32'(b * 32));
      for (int k = 0; k < 8; k++) q_w.push_back({k == 7, pat32(b * 8 + k)});
    end
    q_done.push_back({exp_err == 0, 16'(exp_err)});
  endtask

  // Slave model configuration
  bit stall_en = 1'b0;
  bit bresp_err = 1'b0;
  int corrupt_word = -1;
  int rresp_word = -1;

  // Memory slave for instance A
  logic [31:0] mem [0:255];
  int w_ptr, r_ptr, r_rem;
  bit b_pend;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        awready_a <= 1'b0; wready_a <= 1'b0; arready_a <= 1'b0;
        bvalid_a <= 1'b0; bresp_a <= 2'b00;
        rvalid_a <= 1'b0; rlast_a <= 1'b0; rdata_a <= '0; rresp_a <= 2'b00;
        r_rem = 0; b_pend = 1'b0; w_ptr = 0; r_ptr = 0;
      end else begin
        if (awvalid_a && awready_a) w_ptr = int'(awaddr_a[9:2]);
        if (wvalid_a && wready_a) begin
          mem[w_ptr] = wdata_a;
          w_ptr++;
          if (wlast_a) b_pend = 1'b1;
        end
        if (bvalid_a && bready_a) b_pend = 1'b0;
        if (arvalid_a && arready_a) begin
          r_ptr = int'(araddr_a[9:2]);
          r_rem = int'(arlen_a) + 1;
        end
        if (rvalid_a && rready_a) begin
          r_ptr++;
          r_rem--;
        end
        if (r_rem > 0) begin
          rvalid_a <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
          rdata_a  <= mem[r_ptr] ^ ((r_ptr == corrupt_word) ? 32'h100 : 32'h0);
          rresp_a  <= (r_ptr == rresp_word) ? 2'b10 : 2'b00;
          rlast_a  <= (r_rem == 1);
        end else begin
          rvalid_a <= 1'b0;
          rlast_a  <= 1'b0;
        end
        bvalid_a  <= b_pend;
        bresp_a   <= bresp_err ? 2'b10 : 2'b00;
        awready_a <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        wready_a  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        arready_a <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Ideal single-word slave for instance B
  logic [63:0] mem64;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        bvalid_b <= 1'b0; rvalid_b <= 1'b0; rdata_b <= '0;
      end else begin
        if (wvalid_b) mem64 <= wdata_b;
        if (wvalid_b && wlast_b) bvalid_b <= 1'b1;
        else if (bvalid_b && bready_b) bvalid_b <= 1'b0;
        if (arvalid_b) begin
          rvalid_b <= 1'b1;
          rdata_b  <= mem64;
        end else if (rvalid_b && rready_b) begin
          rvalid_b <= 1'b0;
        end
      end
    end
  end

  // Monitors: sampled on the falling edge, where values are those of the coming handshake.
  int wbeats_a = 0;
  bit done_seen_a = 1'b0, done_seen_b = 1'b0;
  bit aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
  logic [31:0] aw_hold_addr, ar_hold_addr;
  logic [32:0] w_hold_val;
  logic [32:0] ew;
  logic [64:0] ew64;
  logic [16:0] ed;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
      end else begin
        if (aw_hold) check("aw_stall_stable", {awvalid_a, awaddr_a}, {1'b1, aw_hold_addr});
        if (w_hold) check("w_stall_stable", {wvalid_a, wlast_a, wdata_a}, {1'b1, w_hold_val});
        if (ar_hold) check("ar_stall_stable", {arvalid_a, araddr_a}, {1'b1, ar_hold_addr});
        aw_hold = awvalid_a && !awready_a; aw_hold_addr = awaddr_a;
        w_hold = wvalid_a && !wready_a;    w_hold_val = {wlast_a, wdata_a};
        ar_hold = arvalid_a && !arready_a; ar_hold_addr = araddr_a;

        if (awvalid_a && awready_a) begin
          if (q_aw.size() == 0) check("aw_unexpected", 1, 0);
          else check("aw_addr_len", {awlen_a, awaddr_a}, {8'd7, q_aw.pop_front()});
        end
        if (arvalid_a && arready_a) begin
          if (q_ar.size() == 0) check("ar_unexpected", 1, 0);
          else check("ar_addr_len", {arlen_a, araddr_a}, {8'd7, q_ar.pop_front()});
        end
        if (wvalid_a && wready_a) begin
          wbeats_a++;
          if (q_w.size() == 0) check("w_unexpected", 1, 0);
          else begin
            ew = q_w.pop_front();
            check("w_data_last", {wlast_a, wdata_a}, ew);
          end
        end
        if (done_a && !done_seen_a) begin
          if (q_done.size() == 0) check("done_unexpected", 1, 0);
          else begin
            ed = q_done.pop_front();
            check("result_a", {pass_a, err_a}, ed);
          end
        end

        if (awvalid_b) check("aw64_addr_len", {awlen_b, awaddr_b}, 40'h0);
        if (arvalid_b) check("ar64_addr_len", {arlen_b, araddr_b}, 40'h0);
        if (wvalid_b) begin
          if (q_w64.size() == 0) check("w64_unexpected", 1, 0);
          else begin
            ew64 = q_w64.pop_front();
            check("w64_last", wlast_b, ew64[64]);
            check("w64_data", wdata_b, ew64[63:0]);
          end
        end
        if (done_b && !done_seen_b) begin
          if (q_done64.size() == 0) check("done64_unexpected", 1, 0);
          else begin
            ed = q_done64.pop_front();
            check("result_b", {pass_b, err_b}, ed);
          end
        end
      end
      done_seen_a = done_a;
      done_seen_b = done_b;
    end
  end

  task automatic pulse_start(input bit which_b);
    @(negedge clk);
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit which_b, input string name);
    int n;
    n = 0;
    while (!(which_b ? done_b : done_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, which_b ? done_b : done_a, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_a(input int exp_err, input string name);
    push_run_a(exp_err);
    pulse_start(1'b0);
    wait_done(1'b0, name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state_a", {done_a, pass_a, err_a, awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a}, 0);
    check("reset_state_b", {done_b, pass_b, err_b}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal slave: 32 beats of 1..32 at 0x00..0x7C
    run_a(0, "done_ideal");
    for (int i = 0; i < 32; i++) check("mem_contents", mem[i], pat32(i));

    // Corrupted read beat 5 of burst 2
    corrupt_word = 2 * 8 + 5;
    run_a(1, "done_corrupt");
    corrupt_word = -1;

    // SLVERR on every B plus one R beat
    bresp_err = 1'b1;
    rresp_word = 10;
    run_a(5, "done_slverr");
    bresp_err = 1'b0;
    rresp_word = -1;

    // Random stalls on ready/valid
    stall_en = 1'b1;
    run_a(0, "done_stall");
    stall_en = 1'b0;

    // Reset during write beat 3, then a clean rerun
    push_run_a(0);
    wbeats_a = 0;
    pulse_start(1'b0);
    n = 0;
    while (wbeats_a < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("reach_beat3", wbeats_a >= 3, 1);
    #1 rst = 1'b1;
    q_aw.delete(); q_ar.delete(); q_w.delete(); q_done.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_burst_reset", {done_a, err_a, awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_a(0, "done_after_reset");

    // 64-bit, single beat, single burst; second run restarts from S_DONE
    for (int r = 0; r < 2; r++) begin
      q_w64.push_back({1'b1, pat64(0)});
      q_done64.push_back({1'b1, 16'd0});
      pulse_start(1'b1);
      wait_done(1'b1, "done_64");
    end

    check("queues_drained", q_aw.size() + q_ar.size() + q_w.size() + q_done.size()
                            + q_w64.size() + q_done64.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
